// File: rtl/ldl_p1ram_arb2.sv
// Round-robin arbiter sharing one single-port RAM between requesters A and B.
// Define LDL_P1RAM_ARB_INIT_EN to sweep INIT_VAL through the RAM after reset.
module ldl_p1ram_arb2 #(
  parameter int                 DWIDTH   = 8,
  parameter int                 DEEPTH   = 10,
  parameter int                 AWIDTH   = $clog2(DEEPTH),
  parameter logic [DWIDTH-1:0]  INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_vld,
  output logic              a_rdy,
  input  logic              a_we,
  input  logic [AWIDTH-1:0] a_addr,
  input  logic [DWIDTH-1:0] a_din,
  output logic              a_rsp_vld,
  output logic [DWIDTH-1:0] a_rsp_dout,
  input  logic              b_vld,
  output logic              b_rdy,
  input  logic              b_we,
  input  logic [AWIDTH-1:0] b_addr,
  input  logic [DWIDTH-1:0] b_din,
  output logic              b_rsp_vld,
  output logic [DWIDTH-1:0] b_rsp_dout,
  output logic              ram_re,
  output logic              ram_we,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  input  logic [DWIDTH-1:0] ram_dout,
  output logic              init_done
);

  logic              last_b_q, last_b_d;
  logic              rsp_vld_q, rsp_vld_d;
  logic              rsp_tag_q, rsp_tag_d;
  logic              run;
  logic              sweep;
  logic [AWIDTH-1:0] sweep_addr;
  logic [DWIDTH-1:0] sweep_din;
  logic              gnt_a, gnt_b;

  assign sweep_din = INIT_VAL;

`ifdef LDL_P1RAM_ARB_INIT_EN
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == AWIDTH'(DEEPTH - 1)) begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign run        = (state_q == S_RUN);
  assign sweep      = rst_n & (state_q == S_INIT);
  assign sweep_addr = cnt_q;
  assign init_done  = run;
`else
  assign run        = 1'b1;
  assign sweep      = 1'b0;
  assign sweep_addr = '0;
  assign init_done  = 1'b1;
`endif

  // Grants and RAM strobes are gated by rst_n so the RAM port is quiet while reset is held.
  assign gnt_a = rst_n & run & a_vld & (~b_vld | last_b_q);
  assign gnt_b = rst_n & run & b_vld & (~a_vld | ~last_b_q);
  assign a_rdy = gnt_a;
  assign b_rdy = gnt_b;

  always_comb begin
    ram_re   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (sweep) begin
      ram_we   = 1'b1;
      ram_addr = sweep_addr;
      ram_din  = sweep_din;
    end else if (gnt_a) begin
      ram_re   = ~a_we;
      ram_we   = a_we;
      ram_addr = a_addr;
      ram_din  = a_din;
    end else if (gnt_b) begin
      ram_re   = ~b_we;
      ram_we   = b_we;
      ram_addr = b_addr;
      ram_din  = b_din;
    end
  end

  always_comb begin
    last_b_d  = last_b_q;
    if (gnt_a) last_b_d = 1'b0;
    if (gnt_b) last_b_d = 1'b1;
    rsp_vld_d = (gnt_a & ~a_we) | (gnt_b & ~b_we);
    rsp_tag_d = gnt_b;
  end

  // last_gnt starts at B so that A wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_q  <= 1'b1;
      rsp_vld_q <= 1'b0;
      rsp_tag_q <= 1'b0;
    end else begin
      last_b_q  <= last_b_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_tag_q <= rsp_tag_d;
    end
  end

  assign a_rsp_vld  = rsp_vld_q & ~rsp_tag_q;
  assign b_rsp_vld  = rsp_vld_q & rsp_tag_q;
  assign a_rsp_dout = a_rsp_vld ? ram_dout : '0;
  assign b_rsp_dout = b_rsp_vld ? ram_dout : '0;

endmodule

// File: doc/ldl_p1ram_arb2.md
# ldl_p1ram_arb2

Two-requester arbiter and sequencer for a single-port synchronous RAM (1-cycle registered read, `re`/`we`/`addr`/`din`/`dout` interface). It shares one RAM port between requester A and requester B with round-robin arbitration and returns read data on the winning requester's response port. Optionally, it sweeps the RAM to a known value after reset. It sits between two client datapaths and one RAM instance.

## Interface
- `DWIDTH`, 8, data width
- `DEEPTH`, 10, RAM depth in words
- `AWIDTH`, `$clog2(DEEPTH)`, address width
- `INIT_VAL`, 0, word written to every address during the init sweep
- `clk  in  1  clock; all logic on rising edge`
- `rst_n  in  1  asynchronous, active-low reset`
- `a_vld, b_vld  in  1  request valid`
- `a_rdy, b_rdy  out  1  request accepted this cycle`
- `a_we, b_we  in  1  1 = write, 0 = read`
- `a_addr, b_addr  in  AWIDTH  request address`
- `a_din, b_din  in  DWIDTH  write data`
- `a_rsp_vld, b_rsp_vld  out  1  read data valid (1-cycle pulse)`
- `a_rsp_dout, b_rsp_dout  out  DWIDTH  read data`
- `ram_re, ram_we  out  1  RAM read/write enables`
- `ram_addr  out  AWIDTH  RAM address`
- `ram_din  out  DWIDTH  RAM write data`
- `ram_dout  in  DWIDTH  RAM registered read data`
- `init_done  out  1  controller in RUN state`

## Operation
- FSM states:
  - INIT: sweep `ram_we=1`, `ram_addr` counts 0..DEEPTH-1, `ram_din=INIT_VAL`, both `rdy=0`.
  - RUN: arbitrate.
- INIT → RUN after the write to address DEEPTH-1. RUN is terminal until reset.
- Arbitration in RUN:
  - Only one valid: that port wins.
  - Both valid: the port not granted last wins.
  - `last_gnt` resets to B, so A wins the first contention.
  - `last_gnt` updates only on an accepted request.
- Winner i: `i_rdy=1`; `ram_re=~i_we`; `ram_we=i_we`; `ram_addr`/`ram_din` come from port i.
- Loser and idle ports: `rdy=0`. No grant means `ram_re=ram_we=0`.
- A request is accepted when `vld & rdy`. Requesters hold `vld`, `we`, `addr` and `din` until accepted.
- Write: no response. Read: response routed by a registered 1-bit tag.
- Address ≥ DEEPTH is passed through unchecked. Behaviour is undefined; the RAM is not protected.

## Timing
- Reset values:
  - all `rdy`, `rsp_vld`, `ram_re` and `ram_we` are 0
  - `rsp_dout`, `ram_addr` and `ram_din` are 0
  - `init_done` is 0 with INIT, 1 without
  - sweep counter is 0
- `a_rdy`/`b_rdy` and the `ram_*` outputs are combinational from `vld`, `we`, `state` and `last_gnt`. No `rdy` → `vld` dependency is allowed on the requester side.
- Read latency: accepted in cycle N → `x_rsp_vld=1` in cycle N+1. `x_rsp_dout = ram_dout` in that cycle; it is 0 when `rsp_vld=0`.
- Throughput: one access per cycle in total. Back-to-back reads from alternating ports give responses in alternating cycles.
- Init sweep: exactly DEEPTH cycles with `ram_we=1`. `init_done` rises on the edge after the last write. Requests presented during INIT wait, with `rdy=0`.
- `rst_n` asserted mid-sweep or mid-read:
  - sweep counter returns to 0 and INIT restarts
  - a pending response is dropped (`rsp_vld=0`)

## Configuration
- `LDL_P1RAM_ARB_INIT_EN` defined: INIT state and sweep counter are present, as described above.
- `LDL_P1RAM_ARB_INIT_EN` undefined: no INIT state and no counter. The block comes out of reset in RUN with `init_done=1`, and a request is accepted in the first cycle after reset release.

## Test plan
- Macro on, DEEPTH=10, INIT_VAL=0: release reset → 10 consecutive writes to addresses 0..9 with data 0, `init_done` rising in cycle 11. A read of address 5 then returns 0.
- A writes 0x3C to address 2. Next cycle A reads address 2 → `a_rdy=1` both cycles; `a_rsp_vld=1`, `a_rsp_dout=0x3C` one cycle after the read; `b_rsp_vld` stays 0.
- A and B both hold read requests for 4 cycles (addresses 1 and 7, preloaded 0x11 and 0x77) → grants go A, B, A, B; `a_rsp_dout=0x11` and `b_rsp_dout=0x77` on alternating cycles.
- Only B valid for 3 cycles, then both valid → B granted 3 times, then A is granted first (`last_gnt=B`).
- Reset pulse at sweep address 4 → `ram_we` drops during reset; after release the sweep restarts at address 0 and runs the full 10 cycles.
- Macro off → `init_done=1` at reset release; an A write to address 0 is accepted in the first cycle.
